// File: rtl/tcp_option_parser.sv
// Streaming TCP option parser: walks DATA_BYTES option bytes per beat through a kind/length/body FSM.
// Optional build macro TCP_OPT_SACK_EN enables parsing and capture of SACK (kind 5) blocks.
module tcp_option_parser #(
  parameter int unsigned DATA_BYTES      = 4,
  parameter int unsigned MAX_SACK_BLOCKS = 4,
  parameter int unsigned MAX_OPT_BYTES   = 40
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  input  logic [8*DATA_BYTES-1:0]       s_data,
  input  logic [DATA_BYTES-1:0]         s_keep,
  input  logic                          s_last,
  output logic                          done,
  output logic [8:0]                    option_av,
  output logic [15:0]                   mss,
  output logic [7:0]                    scale_wnd,
  output logic [2:0]                    sack_nbr,
  output logic [64*MAX_SACK_BLOCKS-1:0] sack_blocks,
  output logic [63:0]                   time_stp,
  output logic [8:0]                    option_err,
  output logic                          malformed,
  output logic [5:0]                    opt_bytes
);

  localparam int unsigned SW = 64 * MAX_SACK_BLOCKS;
`ifdef TCP_OPT_SACK_EN
  localparam logic [7:0] SACK_MAX_LEN = 8'(2 + 8 * MAX_SACK_BLOCKS);
  localparam logic [8:0] ERR_MASK     = 9'h1FF;
`else
  localparam logic [8:0] ERR_MASK     = 9'h1DF;
`endif

  typedef enum logic [2:0] {S_KIND, S_LEN, S_BODY, S_SKIP, S_PAD} state_t;

  function automatic logic [8:0] kind_bit(input logic [7:0] k);
    kind_bit = (k <= 8'd8) ? (9'd1 << k[3:0]) : 9'd0;
  endfunction

  function automatic logic is_known(input logic [7:0] k);
`ifdef TCP_OPT_SACK_EN
    is_known = (k == 8'd2) || (k == 8'd3) || (k == 8'd4) || (k == 8'd5) || (k == 8'd8);
`else
    is_known = (k == 8'd2) || (k == 8'd3) || (k == 8'd4) || (k == 8'd8);
`endif
  endfunction

  function automatic logic len_ok(input logic [7:0] k, input logic [7:0] len);
    case (k)
      8'd2:    len_ok = (len == 8'd4);
      8'd3:    len_ok = (len == 8'd3);
      8'd4:    len_ok = (len == 8'd2);
`ifdef TCP_OPT_SACK_EN
      8'd5:    len_ok = (len >= 8'd10) && (len <= SACK_MAX_LEN) && (len[2:0] == 3'd2);
`endif
      8'd8:    len_ok = (len == 8'd10);
      default: len_ok = 1'b0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  kind_q, kind_d, rem_q, rem_d, lane_b;
  logic [63:0] cap_q, cap_d, ts_q, ts_d;
  logic [15:0] mss_q, mss_d;
  logic [7:0]  scale_q, scale_d;
  logic [8:0]  av_q, av_d, err_q, err_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        frame_q, frame_d, done_q, done_d, malf_q, malf_d;
`ifdef TCP_OPT_SACK_EN
  logic [2:0]    sack_n_q, sack_n_d, nbr_q, nbr_d;
  logic [SW-1:0] sack_tmp_q, sack_tmp_d, sack_q, sack_d;
`endif

  // Lanes are walked in wire order within one cycle; FSM state carries across beats
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    rem_d   = rem_q;
    cap_d   = cap_q;
    ts_d    = ts_q;
    mss_d   = mss_q;
    scale_d = scale_q;
    av_d    = av_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    malf_d  = malf_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    lane_b  = 8'd0;
`ifdef TCP_OPT_SACK_EN
    sack_n_d   = sack_n_q;
    sack_tmp_d = sack_tmp_q;
    sack_d     = sack_q;
    nbr_d      = nbr_q;
`endif
    if (s_valid) begin
      if (!frame_q) begin
        state_d = S_KIND;
        av_d    = 9'd0;
        err_d   = 9'd0;
        mss_d   = 16'd0;
        scale_d = 8'd0;
        ts_d    = 64'd0;
        malf_d  = 1'b0;
        cnt_d   = 6'd0;
`ifdef TCP_OPT_SACK_EN
        sack_d  = '0;
        nbr_d   = 3'd0;
`endif
      end
      for (int i = 0; i < int'(DATA_BYTES); i++) begin
        if (s_keep[i]) begin
          lane_b = s_data[8*(int'(DATA_BYTES)-1-i) +: 8];
          if (cnt_d != 6'd63) cnt_d = cnt_d + 6'd1;
          if (32'(cnt_d) > MAX_OPT_BYTES) begin
            malf_d  = 1'b1;
            state_d = S_PAD;
          end else begin
            case (state_d)
              S_KIND: begin
                if (lane_b == 8'd0) state_d = S_PAD;
                else if (lane_b != 8'd1) begin
                  kind_d  = lane_b;
                  state_d = S_LEN;
                end
              end
              S_LEN: begin
                if (lane_b < 8'd2) begin
                  malf_d  = 1'b1;
                  state_d = S_PAD;
                end else begin
                  rem_d = lane_b - 8'd2;
                  cap_d = 64'd0;
                  if (is_known(kind_d) && len_ok(kind_d, lane_b)) begin
`ifdef TCP_OPT_SACK_EN
                    sack_n_d = 3'(rem_d >> 3);
`endif
                    if (rem_d == 8'd0) begin
                      av_d    = av_d | kind_bit(kind_d);
                      state_d = S_KIND;
                    end else begin
                      state_d = S_BODY;
                    end
                  end else begin
                    if (is_known(kind_d)) err_d = err_d | kind_bit(kind_d);
                    state_d = (rem_d == 8'd0) ? S_KIND : S_SKIP;
                  end
                end
              end
              S_BODY: begin
                cap_d = {cap_d[55:0], lane_b};
                rem_d = rem_d - 8'd1;
`ifdef TCP_OPT_SACK_EN
                // Every 8th body byte completes one {left,right} SACK block
                if (kind_d == 8'd5 && rem_d[2:0] == 3'd0) begin
                  for (int j = 0; j < int'(MAX_SACK_BLOCKS); j++) begin
                    if (32'(sack_n_d) == 32'(rem_d[7:3]) + 32'(j) + 32'd1)
                      sack_tmp_d[64*j +: 64] = cap_d;
                  end
                end
`endif
                if (rem_d == 8'd0) begin
                  case (kind_d)
                    8'd2: mss_d   = cap_d[15:0];
                    8'd3: scale_d = (cap_d[7:0] > 8'd14) ? 8'd14 : cap_d[7:0];
                    8'd8: ts_d    = cap_d;
`ifdef TCP_OPT_SACK_EN
                    8'd5: begin
                      for (int j = 0; j < int'(MAX_SACK_BLOCKS); j++)
                        sack_d[64*j +: 64] = (32'(j) < 32'(sack_n_d)) ? sack_tmp_d[64*j +: 64] : 64'd0;
                      nbr_d = sack_n_d;
                    end
`endif
                    default: ;
                  endcase
                  av_d    = av_d | kind_bit(kind_d);
                  state_d = S_KIND;
                end
              end
              S_SKIP: begin
                rem_d = rem_d - 8'd1;
                if (rem_d == 8'd0) state_d = S_KIND;
              end
              default: ;
            endcase
          end
        end
      end
      if (s_last) begin
        if (state_d == S_LEN || state_d == S_BODY || state_d == S_SKIP)
          err_d = err_d | kind_bit(kind_d);
        err_d   = err_d & ERR_MASK;
        done_d  = 1'b1;
        frame_d = 1'b0;
      end else begin
        frame_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_KIND;
      kind_q  <= 8'd0;
      rem_q   <= 8'd0;
      cap_q   <= 64'd0;
      ts_q    <= 64'd0;
      mss_q   <= 16'd0;
      scale_q <= 8'd0;
      av_q    <= 9'd0;
      err_q   <= 9'd0;
      cnt_q   <= 6'd0;
      malf_q  <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      rem_q   <= rem_d;
      cap_q   <= cap_d;
      ts_q    <= ts_d;
      mss_q   <= mss_d;
      scale_q <= scale_d;
      av_q    <= av_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      malf_q  <= malf_d;
      frame_q <= frame_d;
      done_q  <= done_d;
    end
  end

`ifdef TCP_OPT_SACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sack_n_q   <= 3'd0;
      sack_tmp_q <= '0;
      sack_q     <= '0;
      nbr_q      <= 3'd0;
    end else begin
      sack_n_q   <= sack_n_d;
      sack_tmp_q <= sack_tmp_d;
      sack_q     <= sack_d;
      nbr_q      <= nbr_d;
    end
  end
  assign sack_nbr    = nbr_q;
  assign sack_blocks = sack_q;
`else
  assign sack_nbr    = 3'd0;
  assign sack_blocks = '0;
`endif

  assign done       = done_q;
  assign option_av  = av_q;
  assign mss        = mss_q;
  assign scale_wnd  = scale_q;
  assign time_stp   = ts_q;
  assign option_err = err_q;
  assign malformed  = malf_q;
  assign opt_bytes  = cnt_q;

endmodule

// File: tb/tb_tcp_option_parser.sv
// Bench for tcp_option_parser: directed segments plus random option streams against a TLV-walk model.
module tb_tcp_option_parser;

  localparam int unsigned DB  = 4;
  localparam int unsigned MSB = 4;
  localparam int unsigned MOB = 40;
  localparam int unsigned DW  = 8 * DB;
  localparam int unsigned SW  = 64 * MSB;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic [DB-1:0] s_keep;
  logic          s_last;
  logic          done;
  logic [8:0]    option_av;
  logic [15:0]   mss;
  logic [7:0]    scale_wnd;
  logic [2:0]    sack_nbr;
  logic [SW-1:0] sack_blocks;
  logic [63:0]   time_stp;
  logic [8:0]    option_err;
  logic          malformed;
  logic [5:0]    opt_bytes;

  always #5 clk = ~clk;

  tcp_option_parser #(.DATA_BYTES(DB), .MAX_SACK_BLOCKS(MSB), .MAX_OPT_BYTES(MOB)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_keep(s_keep),
    .s_last(s_last), .done(done), .option_av(option_av), .mss(mss), .scale_wnd(scale_wnd),
    .sack_nbr(sack_nbr), .sack_blocks(sack_blocks), .time_stp(time_stp),
    .option_err(option_err), .malformed(malformed), .opt_bytes(opt_bytes)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [7:0]    seg_q[$];
  logic [8:0]    e_av, e_err;
  logic [15:0]   e_mss;
  logic [7:0]    e_scale;
  logic [2:0]    e_nbr;
  logic [SW-1:0] e_sack;
  logic [63:0]   e_ts;
  logic          e_malf;
  logic [5:0]    e_cnt;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

`ifdef TCP_OPT_SACK_EN
  localparam bit SACK_ON = 1'b1;
`else
  localparam bit SACK_ON = 1'b0;
`endif

  // Truncation flag for a kind: only kinds 0..8 have a flag, kind 5 only with SACK built
  function automatic logic [8:0] tbit(input int k);
    if (k <= 8 && (SACK_ON || k != 5)) return 9'd1 << k;
    return 9'd0;
  endfunction

  // Reference: walk the whole segment as a list of TLV options
  task automatic model_seg();
    int n, lim, i, k, l, s, nb;
    bit known, ok;
    logic [63:0] blk;
    n = seg_q.size();
    lim = (n > int'(MOB)) ? int'(MOB) : n;
    e_av = '0; e_err = '0; e_mss = '0; e_scale = '0; e_nbr = '0; e_sack = '0; e_ts = '0;
    e_cnt = 6'((n > 63) ? 63 : n);
    e_malf = (n > int'(MOB));
    i = 0;
    while (i < lim) begin
      k = int'(seg_q[i]);
      if (k == 0) break;
      if (k == 1) begin i++; continue; end
      if (i + 1 >= lim) begin
        if (n <= int'(MOB)) e_err = e_err | tbit(k);
        break;
      end
      l = int'(seg_q[i+1]);
      if (l < 2) begin e_malf = 1'b1; break; end
      known = 1'b1;
      case (k)
        2: ok = (l == 4);
        3: ok = (l == 3);
        4: ok = (l == 2);
        8: ok = (l == 10);
        5: begin
          known = SACK_ON;
          ok = ((l - 2) % 8 == 0) && ((l - 2) / 8 >= 1) && ((l - 2) / 8 <= int'(MSB));
        end
        default: begin known = 1'b0; ok = 1'b0; end
      endcase
      if (known && !ok) e_err[k] = 1'b1;
      if (i + l > lim) begin
        if (n <= int'(MOB)) e_err = e_err | tbit(k);
        break;
      end
      s = i + 2;
      if (known && ok) begin
        e_av[k] = 1'b1;
        case (k)
          2: e_mss = {seg_q[s], seg_q[s+1]};
          3: e_scale = (seg_q[s] > 8'd14) ? 8'd14 : seg_q[s];
          8: for (int b = 0; b < 8; b++) e_ts = {e_ts[55:0], seg_q[s+b]};
          5: begin
            nb = (l - 2) / 8;
            e_sack = '0;
            e_nbr = 3'(nb);
            for (int j = 0; j < nb; j++) begin
              blk = '0;
              for (int b = 0; b < 8; b++) blk = {blk[55:0], seg_q[s+8*j+b]};
              e_sack[64*j +: 64] = blk;
            end
          end
          default: ;
        endcase
      end
      i += l;
    end
  endtask

  task automatic drive_idle();
    s_valid = 1'b0;
    s_data  = DW'($urandom);
    s_keep  = DB'($urandom);
    s_last  = 1'($urandom);
  endtask

  task automatic send_seg(input bit rnd);
    int pos, k, n;
    bit last;
    n = seg_q.size();
    pos = 0;
    last = 1'b0;
    while (!last) begin
      if (rnd && $urandom_range(3, 0) == 0) begin
        @(negedge clk);
        drive_idle();
        continue;
      end
      k = int'(DB);
      if (rnd && $urandom_range(2, 0) == 0) k = int'($urandom_range(DB, 1));
      if (k > n - pos) k = n - pos;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      s_keep  = '0;
      for (int j = 0; j < k; j++) begin
        s_data[8*(int'(DB)-1-j) +: 8] = seg_q[pos+j];
        s_keep[j] = 1'b1;
      end
      pos += k;
      last = (pos == n) && !(rnd && k > 0 && $urandom_range(3, 0) == 0);
      s_last = last;
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic check_outputs(input string tag);
    check_eq($sformatf("%s.done", tag), 256'(done), 256'(1));
    check_eq($sformatf("%s.option_av", tag), 256'(option_av), 256'(e_av));
    check_eq($sformatf("%s.mss", tag), 256'(mss), 256'(e_mss));
    check_eq($sformatf("%s.scale_wnd", tag), 256'(scale_wnd), 256'(e_scale));
    check_eq($sformatf("%s.sack_nbr", tag), 256'(sack_nbr), 256'(e_nbr));
    check_eq($sformatf("%s.sack_blocks", tag), 256'(sack_blocks), 256'(e_sack));
    check_eq($sformatf("%s.time_stp", tag), 256'(time_stp), 256'(e_ts));
    check_eq($sformatf("%s.option_err", tag), 256'(option_err), 256'(e_err));
    check_eq($sformatf("%s.malformed", tag), 256'(malformed), 256'(e_malf));
    check_eq($sformatf("%s.opt_bytes", tag), 256'(opt_bytes), 256'(e_cnt));
  endtask

  task automatic run_seg(input string tag, input bit rnd);
    model_seg();
    send_seg(rnd);
    check_outputs(tag);
    @(negedge clk);
    check_eq($sformatf("%s.done_drop", tag), 256'(done), 256'(0));
    check_eq($sformatf("%s.hold_av", tag), 256'(option_av), 256'(e_av));
    check_eq($sformatf("%s.hold_mss", tag), 256'(mss), 256'(e_mss));
  endtask

  task automatic push_rand(input int cnt);
    repeat (cnt) seg_q.push_back(8'($urandom));
  endtask

  task automatic gen_seg();
    int nopt, k, l, tgt;
    int kl[5] = '{2, 3, 4, 5, 8};
    seg_q.delete();
    nopt = int'($urandom_range(6, 0));
    repeat (nopt) begin
      case ($urandom_range(10, 0))
        0: seg_q.push_back(8'd1);
        1: begin seg_q.push_back(8'd2); seg_q.push_back(8'd4); push_rand(2); end
        2: begin
          seg_q.push_back(8'd3); seg_q.push_back(8'd3);
          seg_q.push_back(($urandom_range(1, 0) == 0) ? 8'($urandom_range(20, 0)) : 8'($urandom));
        end
        3: begin seg_q.push_back(8'd4); seg_q.push_back(8'd2); end
        4: begin seg_q.push_back(8'd8); seg_q.push_back(8'd10); push_rand(8); end
        5: begin
          k = int'($urandom_range(MSB + 1, 1));
          seg_q.push_back(8'd5); seg_q.push_back(8'(2 + 8 * k)); push_rand(8 * k);
        end
        6: begin
          k = kl[$urandom_range(4, 0)];
          l = int'($urandom_range(12, 2));
          seg_q.push_back(8'(k)); seg_q.push_back(8'(l)); push_rand(l - 2);
        end
        7: begin
          k = ($urandom_range(1, 0) == 0) ? int'($urandom_range(7, 6)) : int'($urandom_range(255, 9));
          l = int'($urandom_range(8, 2));
          seg_q.push_back(8'(k)); seg_q.push_back(8'(l)); push_rand(l - 2);
        end
        8: begin seg_q.push_back(8'($urandom_range(255, 2))); seg_q.push_back(8'($urandom_range(1, 0))); end
        9: begin seg_q.push_back(8'd0); push_rand(int'($urandom_range(5, 0))); end
        default: begin seg_q.push_back(8'd2); seg_q.push_back(8'd4); push_rand(2); end
      endcase
    end
    if (seg_q.size() > 0 && $urandom_range(3, 0) == 0) begin
      repeat ($urandom_range((seg_q.size() < 6) ? seg_q.size() : 6, 1)) void'(seg_q.pop_back());
    end
    if ($urandom_range(7, 0) == 0) begin
      tgt = int'($urandom_range(50, 41));
      while (seg_q.size() < tgt) seg_q.push_back(8'd1);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("reset.done", 256'(done), 256'(0));
    check_eq("reset.option_av", 256'(option_av), 256'(0));
    check_eq("reset.mss", 256'(mss), 256'(0));
    check_eq("reset.opt_bytes", 256'(opt_bytes), 256'(0));

    seg_q = '{8'h02, 8'h04, 8'h05, 8'hB4, 8'h01, 8'h03, 8'h03, 8'h07, 8'h04, 8'h02,
              8'h08, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    run_seg("basic", 1'b0);
    check_eq("basic.av_const", 256'(option_av), 256'(9'h11C));
    check_eq("basic.mss_const", 256'(mss), 256'(16'h05B4));
    check_eq("basic.scale_const", 256'(scale_wnd), 256'(7));
    check_eq("basic.ts_const", 256'(time_stp), 256'(64'h00000001_00000002));
    check_eq("basic.err_const", 256'(option_err), 256'(0));
    check_eq("basic.bytes_const", 256'(opt_bytes), 256'(20));

    seg_q = '{8'h01, 8'h01, 8'h05, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20};
    run_seg("sack", 1'b0);
`ifdef TCP_OPT_SACK_EN
    check_eq("sack.nbr_const", 256'(sack_nbr), 256'(1));
    check_eq("sack.blk0_const", 256'(sack_blocks[63:0]), 256'(64'h00000010_00000020));
    check_eq("sack.av_const", 256'(option_av), 256'(9'h020));
`else
    check_eq("sack.av_const", 256'(option_av), 256'(0));
`endif
    check_eq("sack.err_const", 256'(option_err), 256'(0));

    seg_q = '{8'h03, 8'h03, 8'h0F, 8'h00};
    run_seg("wsclamp", 1'b0);
    check_eq("wsclamp.scale_const", 256'(scale_wnd), 256'(14));
    check_eq("wsclamp.av3_const", 256'(option_av[3]), 256'(1));

    seg_q = '{8'h02, 8'h05, 8'hAA, 8'hBB};
    run_seg("mssbad", 1'b0);
    check_eq("mssbad.err2_const", 256'(option_err[2]), 256'(1));
    check_eq("mssbad.av2_const", 256'(option_av[2]), 256'(0));
    check_eq("mssbad.mss_const", 256'(mss), 256'(0));

    seg_q = '{8'h1E, 8'h01, 8'h02, 8'h04, 8'h12, 8'h34, 8'h55, 8'h66};
    run_seg("malf", 1'b0);
    check_eq("malf.const", 256'(malformed), 256'(1));
    check_eq("malf.mss_const", 256'(mss), 256'(0));

    seg_q = '{8'h02, 8'h04, 8'h12, 8'h34};
    run_seg("segA", 1'b0);
    @(negedge clk);
    s_valid = 1'b1; s_keep = '1; s_last = 1'b0; s_data = 32'h0204ABCD;
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst.mss", 256'(mss), 256'(0));
    check_eq("midrst.done", 256'(done), 256'(0));
    seg_q.delete();
    run_seg("segC", 1'b0);

    for (int t = 0; t < 250; t++) begin
      gen_seg();
      run_seg($sformatf("rnd%0d", t), 1'b1);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tcp_option_parser.md
Name: tcp_option_parser

Overview:
- Streaming TCP option-field parser; walks DATA_BYTES option bytes per beat through a per-byte kind/length/body state machine.
- Accumulates recognised option values into registered outputs. Pulses done after the last beat of the option region.
- Sits between the TCP header field extractor (which delivers bytes after the 20-byte fixed header) and the connection-state logic.

Parameters:
DATA_BYTES, 4, bytes per input beat (1, 2, 4 or 8); lane 0 = s_data MSB byte
MAX_SACK_BLOCKS, 4, SACK blocks captured (1..4)
MAX_OPT_BYTES, 40, option bytes allowed per segment before malformed

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
s_valid  input  1  beat valid; parser always ready, no backpressure
s_data  input  8*DATA_BYTES  option bytes, lane 0 first on the wire
s_keep  input  DATA_BYTES  lane-valid mask, contiguous from lane 0
s_last  input  1  final beat of option region
done  output  1  one-cycle pulse: outputs final for this segment
option_av  output  9  bit k = option kind k seen and well-formed
mss  output  16  kind 2 value
scale_wnd  output  8  kind 3 shift, clamped to 14
sack_nbr  output  3  SACK blocks captured
sack_blocks  output  64*MAX_SACK_BLOCKS  block i at bits [64i+63:64i], {left,right}
time_stp  output  64  kind 8 {TSval,TSecr}
option_err  output  9  bit k = kind k had a bad length or was truncated
malformed  output  1  length<2 on a non-0/1 kind, or byte count > MAX_OPT_BYTES
opt_bytes  output  6  valid bytes consumed this segment

Behaviour:
- Reset: all outputs 0; FSM in KIND; frame_open=0.
- Latency and holding: the first accepted beat with frame_open=0 clears all accumulators before applying its own bytes, then sets frame_open. On the beat with s_last, done pulses on the next cycle with final outputs, and frame_open clears. Outputs hold until the next segment's first beat.
- Per-byte FSM, evaluated sequentially over lanes 0..DATA_BYTES-1 within one cycle, skipping lanes with s_keep=0. State carries across beats.
  - KIND:
    - 0 → PAD.
    - 1 → KIND.
    - any other kind: latch kind → LEN.
  - LEN:
    - len<2: malformed=1 → PAD.
    - Length check: kind 2 needs len==4; kind 3 needs 3; kind 4 needs 2; kind 5 needs 2+8n with 1≤n≤MAX_SACK_BLOCKS; kind 8 needs 10.
    - Mismatch on kinds 2/3/4/5/8: option_err[kind]=1 and no capture → SKIP for len-2 bytes.
    - Unknown kinds (6, 7, ≥9): skipped silently, no flags.
    - Legal length: remaining=len-2 → BODY, or finish directly when remaining is 0.
  - BODY: shift the byte into the kind's capture register. When remaining reaches 0, commit the value and set option_av[kind] → KIND.
  - SKIP: decrement remaining → KIND at 0.
  - PAD: ignore all bytes until the segment ends.
- Duplicate options: the last well-formed instance wins; option_av stays 1.
- Kind 4 sets option_av[4] only. Kind 5 writes blocks 0..n-1, sack_nbr=n; unused blocks read 0.
- scale_wnd: a value >14 is stored as 14; no error.
- Truncation: s_last arriving while in LEN/BODY/SKIP sets option_err[kind] for kinds ≤8. A partial value is not committed.
- opt_bytes: counts kept lanes, saturating at 63. When the count exceeds MAX_OPT_BYTES, set malformed and force PAD.
- s_valid=0: no state change.
- reset mid-segment: immediate return to the reset state; the next beat starts a new segment.
- s_keep all zero with s_last=1: closes the segment normally (done pulses).

Optional Feature:
- TCP_OPT_SACK_EN defined: kind 5 is parsed and captured as above.
- Not defined:
  - Kind 5 is treated as unknown: skipped by length, no error.
  - option_av[5], option_err[5], sack_nbr and sack_blocks are tied to 0.
  - SACK capture registers are not built.

Test Plan:
- DATA_BYTES=4, beats 02 04 05 B4 | 01 03 03 07 | 04 02 08 0A | 00000001 | 00000002 (last) → done next cycle. Outputs: option_av=0x11C, mss=0x05B4, scale_wnd=7, time_stp=0x00000001_00000002, option_err=0, opt_bytes=20.
- 01 01 05 0A | 00000010 | 00000020 (last), with TCP_OPT_SACK_EN → sack_nbr=1, block0=0x00000010_00000020, option_av=0x020. Without the macro → option_av=0, no error.
- 03 03 0F 00 (last) → scale_wnd=14, option_av[3]=1; the trailing 00 → PAD.
- 02 05 ... (last after 4 bytes) → option_err[2]=1, option_av[2]=0, mss=0.
- 1E 01 ... (kind 30, len 1) → malformed=1; remaining bytes ignored; done still pulses.
- Segment A sets mss; reset asserted mid-segment B; segment C with no options → after C done, all outputs 0.
